imem_boot_loader: RTL and testbench

- Upstream stage of the single-cycle MIPS core.
- Receives a program image as a byte stream over a valid/ready handshake and packs it into 32-bit big-endian words.
- Writes each word into the instruction memory's write port.
- Holds the core in reset (active-high cpu_rst) until the whole image is stored, then releases it so execution starts at word 0.

---
 rtl/imem_boot_loader.sv | 184 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed byte stream, packs it into
// 32-bit big-endian words, writes them to instruction memory and holds the
// MIPS core in reset until the whole image has been stored.
module imem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  // Capacity in words; a header asking for more than this is rejected.
  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t              state_r, state_s;
  logic [15:0]         len_r, len_s;
  logic [1:0]          byte_cnt_r, byte_cnt_s;
  logic [16:0]         word_cnt_r, word_cnt_s;
  // Only the three earlier bytes of a word need to be kept; the fourth
  // arrives on the cycle the word is written.
  logic [23:0]         asm_r, asm_s;
  logic [31:0]         word_s;
  logic [15:0]         hdr_len_s;
  logic                accept_s;
  logic                we_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [31:0]         wdata_s;
  logic                cpu_rst_s;
  logic                done_s;
  logic                error_s;

  // Byte acceptance is allowed only in the receiving states and never on a reload cycle.
  always_comb begin
    if (reload) begin
      in_ready = 1'b0;
    end else begin
      in_ready = (state_r == LEN_HI) || (state_r == LEN_LO) || (state_r == DATA);
    end
  end

  assign accept_s  = in_valid & in_ready;
  assign hdr_len_s = {len_r[15:8], in_data};
  assign word_s    = {asm_r, in_data};

  // Next-state and next-output computation; everything defaults to holding.
  always_comb begin
    state_s    = state_r;
    len_s      = len_r;
    byte_cnt_s = byte_cnt_r;
    word_cnt_s = word_cnt_r;
    asm_s      = asm_r;
    we_s       = 1'b0;
    addr_s     = imem_addr;
    wdata_s    = imem_wdata;
    cpu_rst_s  = cpu_rst;
    done_s     = done;
    error_s    = error;
    if (reload) begin
      // Restart: any partial word is dropped and nothing is written.
      state_s    = LEN_HI;
      len_s      = 16'd0;
      byte_cnt_s = 2'd0;
      word_cnt_s = 17'd0;
      asm_s      = 24'd0;
      cpu_rst_s  = 1'b1;
      done_s     = 1'b0;
      error_s    = 1'b0;
    end else begin
      case (state_r)
        LEN_HI: begin
          if (accept_s) begin
            len_s[15:8] = in_data;
            state_s     = LEN_LO;
          end else begin
            state_s = LEN_HI;
          end
        end
        LEN_LO: begin
          if (accept_s) begin
            len_s = hdr_len_s;
            if (hdr_len_s == 16'd0) begin
              state_s   = DONE;
              cpu_rst_s = 1'b0;
              done_s    = 1'b1;
            end else if ({1'b0, hdr_len_s} > CAP) begin
              state_s = ERR;
              error_s = 1'b1;
            end else begin
              state_s    = DATA;
              byte_cnt_s = 2'd0;
              word_cnt_s = 17'd0;
            end
          end else begin
            state_s = LEN_LO;
          end
        end
        DATA: begin
          if (accept_s) begin
            asm_s      = word_s[23:0];
            byte_cnt_s = byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              we_s       = 1'b1;
              wdata_s    = word_s;
              addr_s     = word_cnt_r[ADDR_W-1:0];
              word_cnt_s = word_cnt_r + 17'd1;
              if (word_cnt_s == {1'b0, len_r}) begin
                state_s = DRAIN;
              end else begin
                state_s = DATA;
              end
            end else begin
              state_s = DATA;
            end
          end else begin
            state_s = DATA;
          end
        end
        DRAIN: begin
          // Final write pulse is visible now; release the core next edge.
          state_s   = DONE;
          cpu_rst_s = 1'b0;
          done_s    = 1'b1;
        end
        DONE: begin
          state_s = DONE;
        end
        ERR: begin
          state_s = ERR;
        end
        default: begin
          state_s = LEN_HI;
        end
      endcase
    end
  end

  // State and registered outputs, asynchronously cleared by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= LEN_HI;
      len_r      <= 16'd0;
      byte_cnt_r <= 2'd0;
      word_cnt_r <= 17'd0;
      asm_r      <= 24'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_r    <= state_s;
      len_r      <= len_s;
      byte_cnt_r <= byte_cnt_s;
      word_cnt_r <= word_cnt_s;
      asm_r      <= asm_s;
      imem_we    <= we_s;
      imem_addr  <= addr_s;
      imem_wdata <= wdata_s;
      cpu_rst    <= cpu_rst_s;
      done       <= done_s;
      error      <= error_s;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: randomized byte streams, expected writes
// queued from a stream-level model, compared by an independent monitor.
module tb_imem_boot_loader;
  localparam int AW = 2;
  localparam int CAPW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          reload = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          error;

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] img_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int done_cyc = -1;
  int acc_cyc = -1;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every write pulse is matched against the scoreboard queue.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, none expected", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(e.addr));
        chk("write_data", imem_wdata, e.data);
      end
      chk("cpu_rst_during_write", 32'(cpu_rst), 32'd1);
    end
    if (done === 1'b1 && prev_done === 1'b0) done_cyc = cyc;
    prev_done = done;
  end

  // Present one byte until it is accepted; idle cycles injected with gap% probability.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
      end
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %h never accepted", b);
    end
    acc_cyc = cyc;
  endtask

  // Reference model: derive expected writes and final status from the stream rules.
  task automatic run_image(input int gap, input string tag);
    int n;
    bit legal;
    wr_t w;
    n = {img_q[0], img_q[1]};
    legal = (n <= CAPW);
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        w.addr = AW'(i);
        w.data = {img_q[2+4*i], img_q[3+4*i], img_q[4+4*i], img_q[5+4*i]};
        exp_q.push_back(w);
      end
    end
    last_we_cyc = -1;
    done_cyc = -1;
    foreach (img_q[i]) send_byte(img_q[i], gap);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 20 && !(done || error); k++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, "_done"}, 32'(done), legal ? 32'd1 : 32'd0);
    chk({tag, "_error"}, 32'(error), legal ? 32'd0 : 32'd1);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), legal ? 32'd0 : 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    if (legal && n > 0) chk({tag, "_release_timing"}, 32'(done_cyc), 32'(last_we_cyc + 1));
    if (n == 0) chk({tag, "_empty_done_timing"}, 32'(done_cyc), 32'(acc_cyc));
    exp_q.delete();
  endtask

  // Reload pulse with a byte offered on the same cycle, which must be refused.
  task automatic do_reload();
    @(negedge clk);
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    #1;
    chk("reload_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_error", 32'(error), 32'd0);
    chk("reload_in_ready_after", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // Partial load of a 3-word image: one complete word plus two bytes.
  task automatic partial_load();
    wr_t w;
    img_q = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    w.addr = '0;
    w.data = 32'h11223344;
    exp_q.push_back(w);
    foreach (img_q[i]) send_byte(img_q[i], 0);
  endtask

  task automatic fresh_deadbeef(input string tag);
    img_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_image(0, tag);
  endtask

  initial begin
    int n;
    #2 rst = 1'b0;
    #1 check_reset_values("por");
    chk("por_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    img_q = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    run_image(0, "two_words");

    do_reload();
    img_q = '{8'h00, 8'h00};
    run_image(0, "empty");

    do_reload();
    img_q = '{8'h00, 8'h05};
    run_image(0, "oversize");

    do_reload();
    img_q = '{8'h00, 8'h04};
    repeat (16) img_q.push_back(8'($urandom));
    run_image(0, "full");

    do_reload();
    img_q = '{8'h00, 8'h03};
    repeat (12) img_q.push_back(8'($urandom));
    run_image(30, "gappy");

    do_reload();
    partial_load();
    do_reload();
    chk("reload_discard", 32'(exp_q.size()), 32'd0);
    fresh_deadbeef("after_reload");

    do_reload();
    partial_load();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1 check_reset_values("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    chk("rst_discard", 32'(exp_q.size()), 32'd0);
    fresh_deadbeef("after_rst");

    for (int it = 0; it < 6; it++) begin
      do_reload();
      n = int'($urandom_range(6));
      img_q = '{8'h00, 8'(n)};
      if (n <= CAPW) repeat (4 * n) img_q.push_back(8'($urandom));
      run_image(20, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
